mul_share_sched: RTL and testbench

//  Round-robin scheduler sharing one multiply-by-repeated-addition datapath among NREQ requesters.

---
 rtl/mul_share_pkg.sv | 28 ++
 rtl/mul_share_sched_if.sv | 31 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/mul_share_sched.sv | 146 ++++++++++++++
 tb/tb_mul_share_sched.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// Shared encodings and helpers for the shared multiplier scheduler.
package mul_share_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LDA  = 3'd1;
  localparam state_t S_LDB  = 3'd2;
  localparam state_t S_ACC  = 3'd3;
  localparam state_t S_RESP = 3'd4;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_share_sched_if.sv
// Client-side request/response bundle of the shared multiplier scheduler.
interface mul_share_sched_if
  import mul_share_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
);

  localparam int unsigned GW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat;
  logic [NREQ*WIDTH-1:0] b_flat;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  // Requesters drive operands and request levels.
  modport master (
    output req, a_flat, b_flat,
    input  ack, result, busy, grant_id
  );

  // The scheduler consumes requests and returns products.
  modport slave (
    input  req, a_flat, b_flat,
    output ack, result, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [NREQ-1:0] grant_onehot,
  output logic [GW-1:0]   grant_idx,
  output logic            any
);

  logic          found;
  logic [GW-1:0] idx;

  // Scan last_grant+1 .. last_grant (inclusive), keeping the first hit.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = GW'((32'(last_grant) + k) % NREQ);
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath.
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_share_sched_if.slave     bus,
  output logic [WIDTH-1:0]     data_bus,
  output logic                 ldA,
  output logic                 ldB,
  output logic                 ldP,
  output logic                 clrP,
  output logic                 decB,
  input  logic                 eqz,
  input  logic [WIDTH-1:0]     p_in
);

  localparam int unsigned GW = clog2(NREQ);

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [NREQ-1:0]   grant_oh_q, grant_oh_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [NREQ-1:0]   arb_oh;
  logic [GW-1:0]     arb_idx;
  logic              arb_any;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req          (bus.req),
    .last_grant   (last_grant_q),
    .grant_onehot (arb_oh),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  // Unpack flat operand buses per requester.
  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign a_arr[i] = bus.a_flat[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.b_flat[i*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed load sequence, then accumulate until the counter hits zero.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = arb_any ? S_LDA : S_IDLE;
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_ACC;
      S_ACC:   state_d = eqz ? S_RESP : S_ACC;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls and operand steering; ACC controls follow eqz directly.
  always_comb begin
    data_bus = '0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    ldP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    case (state_q)
      S_LDA: begin
        data_bus = a_arr[grant_id_q];
        ldA      = 1'b1;
      end
      S_LDB: begin
        data_bus = b_arr[grant_id_q];
        ldB      = 1'b1;
        clrP     = 1'b1;
      end
      S_ACC: begin
        ldP  = ~eqz;
        decB = ~eqz;
      end
      default: ;
    endcase
  end

  // Grant capture in IDLE, product/ack capture on the last ACC cycle, pointer update in RESP.
  always_comb begin
    grant_id_d   = grant_id_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    ack_d        = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant_id_d = arb_idx;
          grant_oh_d = arb_oh;
        end
      end
      S_ACC: begin
        if (eqz) begin
          result_d = p_in;
          ack_d    = grant_oh_q;
        end
      end
      S_RESP:  last_grant_d = grant_id_q;
      default: ;
    endcase
  end

  // Grant, pointer, result and ack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_q   <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= GW'(NREQ - 1);
      result_q     <= '0;
      ack_q        <= '0;
    end else begin
      grant_id_q   <= grant_id_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.result   = result_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched with a behavioural repeated-addition datapath.
module tb_mul_share_sched;
  import mul_share_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 16;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] prod;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_bus;
  logic [WIDTH-1:0] p_in;
  logic             ldA, ldB, ldP, clrP, decB, eqz;
  logic [WIDTH-1:0] dp_a, dp_b, dp_p;

  exp_t sb_q[$];
  int   n_checks, n_errors;
  int   n_acks, cyc, last_ack_cyc;
  int   n_ldp, n_decb, n_overlap;

  mul_share_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  mul_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .data_bus (data_bus),
    .ldA      (ldA),
    .ldB      (ldB),
    .ldP      (ldP),
    .clrP     (clrP),
    .decB     (decB),
    .eqz      (eqz),
    .p_in     (p_in)
  );

  assign eqz  = (dp_b == '0);
  assign p_in = dp_p;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Datapath model: never reset, so a stale product survives a scheduler reset.
  initial begin
    dp_a = '0;
    dp_b = '0;
    dp_p = '0;
    forever begin
      @(posedge clk);
      if (ldA) dp_a <= data_bus;
      if (ldB) dp_b <= data_bus;
      if (clrP) dp_p <= '0;
      else if (ldP) dp_p <= dp_p + dp_a;
      if (decB) dp_b <= dp_b - 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: control activity counts and scoreboard pops on every ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ldP) n_ldp++;
      if (decB) n_decb++;
      if ((ldA || ldB || clrP) && (ldP || decB)) n_overlap++;
      if (bus.ack != '0) begin
        n_acks++;
        last_ack_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("ack_onehot", 32'(bus.ack), 32'(1) << e.id);
          check("ack_grant_id", 32'(bus.grant_id), e.id);
          check("ack_result", 32'(bus.result), 32'(e.prod));
        end
      end
    end
  end

  task automatic start_op(input int id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input bit push);
    logic [31:0] full;
    exp_t        e;
    bus.a_flat[id*WIDTH +: WIDTH] = a;
    bus.b_flat[id*WIDTH +: WIDTH] = b;
    bus.req[id] = 1'b1;
    if (push) begin
      full   = a * b;
      e.id   = id;
      e.prod = full[WIDTH-1:0];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k;
    k = 0;
    while (n_acks < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_acks < target) check("ack_timeout", 32'(n_acks), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 32'(0));
    check({tag, "_result"}, 32'(bus.result), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'(0));
    check({tag, "_data_bus"}, 32'(data_bus), 32'(0));
    check({tag, "_ctrl"}, 32'({ldA, ldB, ldP, clrP, decB}), 32'(0));
  endtask

  task automatic single_op(input string tag, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    int base, t0, l0, d0;
    base = n_acks;
    l0   = n_ldp;
    d0   = n_decb;
    t0   = cyc;
    start_op(id, a, b, 1'b1);
    wait_acks(base + 1, 100);
    check({tag, "_latency"}, 32'(last_ack_cyc - t0), 32'(4) + 32'(b));
    check({tag, "_ldp_cycles"}, 32'(n_ldp - l0), 32'(b));
    check({tag, "_decb_cycles"}, 32'(n_decb - d0), 32'(b));
    bus.req[id] = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    n_checks = 0; n_errors = 0; n_acks = 0; last_ack_cyc = 0;
    n_ldp = 0; n_decb = 0; n_overlap = 0;
    rst        = 1'b1;
    bus.req    = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Basic products, zero multiplier and wrap-around.
    single_op("t1", 0, 16'd7, 16'd5);
    single_op("t2", 2, 16'd9, 16'd0);
    single_op("t4", 3, 16'hFFFF, 16'd3);

    // All requesting with b=1: round-robin 0,1,2,3 then 0 again.
    base = n_acks;
    for (int i = 0; i < 4; i++) start_op(i, WIDTH'(11 * (i + 1)), 16'd1, 1'b1);
    sb_q.push_back('{0, 16'd11});
    wait_acks(base + 5, 200);
    bus.req = '0;
    @(negedge clk);
    #1;

    // Reset in the middle of ACC aborts without an ack.
    start_op(1, 16'd5, 16'd10, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.req[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    single_op("t5", 1, 16'd6, 16'd3);

    // Requester drops during ACC; a request raised while busy is served next.
    base = n_acks;
    start_op(3, 16'd3, 16'd6, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("t6_busy_in_acc", 32'(bus.busy), 32'(1));
    bus.req[3] = 1'b0;
    start_op(1, 16'd4, 16'd2, 1'b1);
    wait_acks(base + 2, 100);
    bus.req[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    check("ctrl_overlap", 32'(n_overlap), 32'(0));
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
